// File: rtl/icache_pkg.sv
// Shared constants for the direct-mapped instruction cache: state encoding, widths, reset polarity.
// Latency/backpressure: n/a (package only).
package icache_pkg;

  localparam int WORD_W         = 32;
  localparam int INDEX_BITS_DEF = 4;
  localparam logic RESET_ACTIVE = 1'b0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the icache: combinational read by index, synchronous write on fill.
// Latency: read 0 cycles, write visible next cycle; no backpressure (write enable is pre-qualified by the caller).
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [INDEX_BITS-1:0]            rd_idx,
  output logic                             rd_valid,
  output logic [WORD_W-INDEX_BITS-3:0]     rd_tag,
  output logic [WORD_W-1:0]                rd_data,
  input  logic                             wr_en,
  input  logic [INDEX_BITS-1:0]            wr_idx,
  input  logic [WORD_W-INDEX_BITS-3:0]     wr_tag,
  input  logic [WORD_W-1:0]                wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]              valid;
  logic [WORD_W-INDEX_BITS-3:0]  tag_mem  [LINES];
  logic [WORD_W-1:0]             data_mem [LINES];

  // Only the valid bits are reset; stale tag/data are harmless once invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_ACTIVE) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache; hits answer 1 cycle after the request, misses 1 cycle after ins_rdy.
// Backpressure: fetch_ready drops for the whole miss; rdy=0 freezes every register including the ic_flag pulse.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        ins_valid,
  output logic [31:0] ins_out,
  output logic [31:0] ins_pc,
  input  logic        clear,
  output logic        ic_flag,
  output logic [31:0] ins_addr,
  input  logic        ic_enable,
  input  logic [31:0] ins,
  input  logic        ins_rdy
);

  localparam int TAG_W = WORD_W - INDEX_BITS - 2;

  logic [0:0]            state;
  logic                  drop;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_W-1:0]      fill_tag;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [WORD_W-1:0]     rd_data;
  logic                  hit;
  logic                  fill_en;
  logic                  unused_inputs;

  assign req_idx  = fetch_addr[INDEX_BITS+1:2];
  assign req_tag  = fetch_addr[WORD_W-1:INDEX_BITS+2];
  assign fill_idx = ins_addr[INDEX_BITS+1:2];
  assign fill_tag = ins_addr[WORD_W-1:INDEX_BITS+2];

  assign hit     = rd_valid && (rd_tag == req_tag);
  assign fill_en = rdy && (state == ST_WAIT) && ins_rdy;

  // ic_enable is status only: the controller latches ic_flag even when busy.
  assign unused_inputs = ^{ic_enable, fetch_addr[1:0]};

  icache_array #(
    .INDEX_BITS(INDEX_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_en),
    .wr_idx   (fill_idx),
    .wr_tag   (fill_tag),
    .wr_data  (ins)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_ACTIVE) begin
      state       <= ST_IDLE;
      fetch_ready <= 1'b1;
      ins_valid   <= 1'b0;
      ins_out     <= '0;
      ins_pc      <= '0;
      ic_flag     <= 1'b0;
      ins_addr    <= '0;
      drop        <= 1'b0;
    end else if (rdy) begin
      ins_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fetch_req && !clear) begin
            if (hit) begin
              ins_valid <= 1'b1;
              ins_out   <= rd_data;
              ins_pc    <= {fetch_addr[31:2], 2'b00};
            end else begin
              ic_flag     <= 1'b1;
              ins_addr    <= {fetch_addr[31:2], 2'b00};
              state       <= ST_WAIT;
              fetch_ready <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          ic_flag <= 1'b0;
          if (ins_rdy) begin
            // A redirect seen earlier (drop) or in this very cycle (clear) suppresses the response but not the fill.
            state       <= ST_IDLE;
            fetch_ready <= 1'b1;
            drop        <= 1'b0;
            if (!drop && !clear) begin
              ins_valid <= 1'b1;
              ins_out   <= ins;
              ins_pc    <= ins_addr;
            end
          end else if (clear) begin
            drop <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
